// File: rtl/bus_arbiter.sv
// Two-master byte-bus arbiter: serialises CPU and DMA accesses onto one memory bus,
// waits out the fixed RAM read latency and returns a single-cycle acknowledge.
module bus_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [19:0] m0_address,
    input  logic [7:0]  m0_wdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [19:0] m1_address,
    input  logic [7:0]  m1_wdata,
    output logic        m1_ack,
    output logic [7:0]  rdata,
    output logic [19:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t     state;
    logic       we_r;
    logic       last;
    logic [3:0] cnt;
    logic       grant;
    logic       winner;

    // On a tie the master that did not win last time goes next.
    always_comb begin
        grant  = m0_req | m1_req;
        winner = (m0_req && m1_req) ? ~last : m1_req;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            owner       <= 1'b0;
            last        <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            we_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    mem_we <= 1'b0;
                    if (grant) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        owner       <= winner;
                        last        <= winner;
                        mem_address <= winner ? m1_address : m0_address;
                        mem_wdata   <= winner ? m1_wdata   : m0_wdata;
                        we_r        <= winner ? m1_we      : m0_we;
                        mem_we      <= winner ? m1_we      : m0_we;
                        cnt         <= LAT;
                    end
                end
                ACCESS: begin
                    // Strobe only lives for the first ACCESS cycle.
                    mem_we <= 1'b0;
                    cnt    <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!we_r) begin
                            rdata <= mem_rdata;
                        end
                        m0_ack <= ~owner;
                        m1_ack <= owner;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a LATENCY=2 instance for most scenarios and a
// LATENCY=5 instance for the withdrawn-request case, each fed by a delayed RAM model.
module tb_bus_arbiter;

    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 5;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [19:0] m0_address, m1_address, mem_address;
    logic [7:0]  m0_wdata, m1_wdata, rdata, mem_wdata, mem_rdata;
    logic        mem_we, owner, busy;

    logic        b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack;
    logic [19:0] b_m0_address, b_m1_address, b_mem_address;
    logic [7:0]  b_m0_wdata, b_m1_wdata, b_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_mem_we, b_owner, b_busy;

    bus_arbiter #(.LATENCY(LAT_A)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    bus_arbiter #(.LATENCY(LAT_B)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_address(b_m0_address), .m0_wdata(b_m0_wdata), .m0_ack(b_m0_ack),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_address(b_m1_address), .m1_wdata(b_m1_wdata), .m1_ack(b_m1_ack),
        .rdata(b_rdata), .mem_address(b_mem_address), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .owner(b_owner), .busy(b_busy)
    );

    // RAM contents: one fixed word, everything else derived from the address.
    function automatic logic [7:0] ram_word(input logic [19:0] a);
        if (a == 20'hFE010) return 8'hEA;
        return a[7:0] ^ 8'h5A;
    endfunction

    // Address pipeline so read data only becomes valid LATENCY edges after presentation.
    logic [19:0] hist_a [0:15];
    logic [19:0] hist_b [0:15];
    always @(posedge clock) begin
        hist_a[0] <= mem_address;
        hist_b[0] <= b_mem_address;
        for (int i = 1; i < 16; i++) begin
            hist_a[i] <= hist_a[i-1];
            hist_b[i] <= hist_b[i-1];
        end
    end
    assign mem_rdata   = ram_word(hist_a[LAT_A-2]);
    assign b_mem_rdata = ram_word(hist_b[LAT_B-2]);

    int unsigned cyc = 0;
    int unsigned ack0_total = 0;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (m0_ack === 1'b1) ack0_total <= ack0_total + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL rst_m0_ack: got %b, expected 0", m0_ack); end
        vectors++; if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL rst_m1_ack: got %b, expected 0", m1_ack); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b, expected 0", mem_we); end
        vectors++; if (mem_address !== 20'h0) begin miscompares++; $display("FAIL rst_mem_address: got %h, expected 00000", mem_address); end
        vectors++; if (mem_wdata !== 8'h0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h, expected 00", mem_wdata); end
        vectors++; if (rdata !== 8'h0) begin miscompares++; $display("FAIL rst_rdata: got %h, expected 00", rdata); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL rst_owner: got %b, expected 0", owner); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        vectors++; if (b_busy !== 1'b0) begin miscompares++; $display("FAIL rst_b_busy: got %b, expected 0", b_busy); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        m0_we = 1'b0; m0_address = 20'hFE010; m0_req = 1'b1;
        step();
        vectors++; if (mem_address !== 20'hFE010) begin miscompares++; $display("FAIL rd_mem_address: got %h, expected fe010", mem_address); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rd_busy: got %b, expected 1", busy); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL rd_owner: got %b, expected 0", owner); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rd_mem_we: got %b, expected 0", mem_we); end
        step();
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL rd_early_ack: got %b, expected 0", m0_ack); end
        step();
        vectors++; if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL rd_m0_ack: got %b, expected 1", m0_ack); end
        vectors++; if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL rd_m1_ack: got %b, expected 0", m1_ack); end
        vectors++; if (rdata !== 8'hEA) begin miscompares++; $display("FAIL rd_rdata: got %h, expected ea", rdata); end
        m0_req = 1'b0;
        step();
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL rd_ack_width: got %b, expected 0", m0_ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_idle_busy: got %b, expected 0", busy); end
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_no_regrant: got %b, expected 0", busy); end
    endtask

    task automatic test_single_write();
        m1_we = 1'b1; m1_address = 20'hB8000; m1_wdata = 8'h41; m1_req = 1'b1;
        step();
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_mem_we: got %b, expected 1", mem_we); end
        vectors++; if (mem_wdata !== 8'h41) begin miscompares++; $display("FAIL wr_mem_wdata: got %h, expected 41", mem_wdata); end
        vectors++; if (mem_address !== 20'hB8000) begin miscompares++; $display("FAIL wr_mem_address: got %h, expected b8000", mem_address); end
        vectors++; if (owner !== 1'b1) begin miscompares++; $display("FAIL wr_owner: got %b, expected 1", owner); end
        step();
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL wr_strobe_width: got %b, expected 0", mem_we); end
        step();
        vectors++; if (m1_ack !== 1'b1) begin miscompares++; $display("FAIL wr_m1_ack: got %b, expected 1", m1_ack); end
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL wr_m0_ack: got %b, expected 0", m0_ack); end
        vectors++; if (rdata !== 8'hEA) begin miscompares++; $display("FAIL wr_rdata_held: got %h, expected ea", rdata); end
        m1_req = 1'b0; m1_we = 1'b0;
        step();
        step();
    endtask

    task automatic test_contention();
        logic        exp_owner;
        logic [19:0] exp_addr;
        reset_n = 1'b0;
        m0_we = 1'b0; m0_address = 20'h12345; m0_req = 1'b1;
        m1_we = 1'b0; m1_address = 20'hABCDE; m1_req = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_owner = (i % 2 == 1);
            exp_addr  = exp_owner ? 20'hABCDE : 20'h12345;
            step();
            vectors++; if (owner !== exp_owner) begin miscompares++; $display("FAIL cont_owner[%0d]: got %b, expected %b", i, owner, exp_owner); end
            vectors++; if (mem_address !== exp_addr) begin miscompares++; $display("FAIL cont_addr[%0d]: got %h, expected %h", i, mem_address, exp_addr); end
            step();
            step();
            vectors++; if (m0_ack !== ~exp_owner) begin miscompares++; $display("FAIL cont_m0_ack[%0d]: got %b, expected %b", i, m0_ack, ~exp_owner); end
            vectors++; if (m1_ack !== exp_owner) begin miscompares++; $display("FAIL cont_m1_ack[%0d]: got %b, expected %b", i, m1_ack, exp_owner); end
            vectors++; if (rdata !== ram_word(exp_addr)) begin miscompares++; $display("FAIL cont_rdata[%0d]: got %h, expected %h", i, rdata, ram_word(exp_addr)); end
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            step();
        end
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cont_final_idle: got %b, expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int unsigned start_total;
        int unsigned prev_cyc;
        int          lat;
        logic        got;
        logic [19:0] addr;
        start_total = ack0_total;
        prev_cyc    = 0;
        for (int i = 0; i < 3; i++) begin
            addr = 20'h00100 + 20'(i * 16'h0111);
            m0_we = 1'b0; m0_address = addr; m0_req = 1'b1;
            got = 1'b0;
            lat = 0;
            for (int n = 0; n < 12; n++) begin
                step();
                lat++;
                if (m0_ack === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL b2b_ack_timeout[%0d]: got %b, expected 1", i, got); end
            vectors++; if (rdata !== ram_word(addr)) begin miscompares++; $display("FAIL b2b_rdata[%0d]: got %h, expected %h", i, rdata, ram_word(addr)); end
            if (i == 0) begin
                vectors++; if (lat !== 3) begin miscompares++; $display("FAIL b2b_first_latency: got %0d, expected 3", lat); end
            end else begin
                vectors++; if (cyc - prev_cyc !== 4) begin miscompares++; $display("FAIL b2b_spacing[%0d]: got %0d, expected 4", i, cyc - prev_cyc); end
            end
            prev_cyc = cyc;
            m0_req = 1'b0;
            step();
        end
        repeat (6) step();
        vectors++; if (ack0_total - start_total !== 3) begin miscompares++; $display("FAIL b2b_ack_count: got %0d, expected 3", ack0_total - start_total); end
    endtask

    task automatic test_reset_mid_access();
        m0_we = 1'b0; m0_address = 20'h55555; m0_req = 1'b1;
        step();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b, expected 1", busy); end
        step();
        reset_n = 1'b0;
        m0_req = 1'b0;
        m1_we = 1'b0; m1_address = 20'h0F0F0; m1_req = 1'b1;
        step();
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL mid_m0_ack: got %b, expected 0", m0_ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b, expected 0", busy); end
        vectors++; if (mem_address !== 20'h0) begin miscompares++; $display("FAIL mid_rst_address: got %h, expected 00000", mem_address); end
        vectors++; if (rdata !== 8'h0) begin miscompares++; $display("FAIL mid_rst_rdata: got %h, expected 00", rdata); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL mid_rst_owner: got %b, expected 0", owner); end
        reset_n = 1'b1;
        step();
        vectors++; if (owner !== 1'b1) begin miscompares++; $display("FAIL mid_m1_owner: got %b, expected 1", owner); end
        vectors++; if (mem_address !== 20'h0F0F0) begin miscompares++; $display("FAIL mid_m1_address: got %h, expected 0f0f0", mem_address); end
        step();
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL mid_stale_ack: got %b, expected 0", m0_ack); end
        step();
        vectors++; if (m1_ack !== 1'b1) begin miscompares++; $display("FAIL mid_m1_ack: got %b, expected 1", m1_ack); end
        vectors++; if (rdata !== 8'hAA) begin miscompares++; $display("FAIL mid_m1_rdata: got %h, expected aa", rdata); end
        m1_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_req_withdrawn();
        b_m0_we = 1'b0; b_m0_address = 20'h00777; b_m0_req = 1'b1;
        step();
        vectors++; if (b_busy !== 1'b1) begin miscompares++; $display("FAIL wd_busy: got %b, expected 1", b_busy); end
        vectors++; if (b_owner !== 1'b0) begin miscompares++; $display("FAIL wd_owner: got %b, expected 0", b_owner); end
        b_m0_req = 1'b0;
        for (int n = 1; n < 5; n++) begin
            step();
            vectors++; if (b_m0_ack !== 1'b0) begin miscompares++; $display("FAIL wd_early_ack[k+%0d]: got %b, expected 0", n, b_m0_ack); end
        end
        step();
        vectors++; if (b_m0_ack !== 1'b1) begin miscompares++; $display("FAIL wd_ack_k5: got %b, expected 1", b_m0_ack); end
        vectors++; if (b_m1_ack !== 1'b0) begin miscompares++; $display("FAIL wd_m1_ack: got %b, expected 0", b_m1_ack); end
        vectors++; if (b_rdata !== 8'h2D) begin miscompares++; $display("FAIL wd_rdata: got %h, expected 2d", b_rdata); end
        step();
        vectors++; if (b_m0_ack !== 1'b0) begin miscompares++; $display("FAIL wd_ack_width: got %b, expected 0", b_m0_ack); end
        step();
        vectors++; if (b_busy !== 1'b0) begin miscompares++; $display("FAIL wd_idle: got %b, expected 0", b_busy); end
    endtask

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_address = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_address = '0; m1_wdata = '0;
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_address = '0; b_m0_wdata = '0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_address = '0; b_m1_wdata = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_access();
        test_req_withdrawn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master byte-bus arbiter between the CPU core and a second bus master (DMA / serial loader). It drives the single 20-bit address, 8-bit data memory bus that feeds the address-decode router and the on-chip RAM blocks. It serialises accesses, inserts the fixed read latency of the synchronous RAMs, and returns one-cycle acknowledges. Clocked in the CPU clock domain (25 MHz).

## Interface
- LATENCY, 2, clock cycles from address presentation to valid mem_rdata; legal range 1..15
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- m0_req  in  1  CPU access request, held until m0_ack
- m0_we  in  1  CPU write enable (1 = write), valid with m0_req
- m0_address  in  20  CPU byte address
- m0_wdata  in  8  CPU write data
- m0_ack  out  1  one-cycle completion pulse to CPU
- m1_req, m1_we, m1_address, m1_wdata, m1_ack: same as m0_*, second master
- rdata  out  8  read data for the acknowledged master, valid while its ack is high, held until the next capture
- mem_address  out  20  address to router
- mem_wdata  out  8  write data to router
- mem_we  out  1  write strobe to router
- mem_rdata  in  8  read data from router
- owner  out  1  master of the current or last access (0 = m0, 1 = m1)
- busy  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if no request is pending, stay in IDLE. If exactly one master requests, grant it. If both request, grant the master not equal to `last`; `last` resets to 1, so m0 wins the first tie. On grant, register address, wdata and we from the winner into mem_address, mem_wdata and we_r. Set owner = winner, last = winner, cnt = LATENCY, and go to ACCESS.
- ACCESS: mem_we = we_r only in the first ACCESS cycle, so a write strobe is exactly 1 cycle. cnt decrements each cycle. When cnt == 1, capture mem_rdata into rdata (reads only; on writes rdata is unchanged) and go to DONE.
- DONE: assert m{owner}_ack for exactly one cycle, then go to IDLE. Requests are not sampled in DONE.
- mem_address and mem_wdata hold their value after the access until the next grant.
- A master that drops req during ACCESS still gets its access completed and its ack pulsed. The master ignores that ack.
- Master request signals are not changed by the arbiter. m0 and m1 never see ack in the same cycle.
- Reset: state IDLE, m0_ack = m1_ack = 0, mem_we = 0, mem_address = 0, mem_wdata = 0, rdata = 0, owner = 0, last = 1, busy = 0, cnt = 0. Reset during ACCESS or DONE aborts the access; no ack is issued.

## Timing
- Request seen at edge k (IDLE): mem_address valid from edge k, mem_we high during cycle k..k+1 (writes only). rdata is captured at edge k+LATENCY. Ack is high from edge k+LATENCY for one cycle. The FSM is back in IDLE at k+LATENCY+1, and the next grant happens at edge k+LATENCY+2 at the earliest.
- Throughput: one access per LATENCY+2 cycles. With LATENCY = 2, there are 4 cycles per access.
- A master deasserts req on the edge after seeing ack. Because DONE does not sample requests, this gives no double access.
- Fairness: under continuous requests from both masters, grants alternate strictly m0, m1, m0, ...; no master waits more than one foreign access.

## Test plan
- Single read, LATENCY = 2: m0_req with m0_address = 20'hFE010 and the router returning 8'hEA -> mem_address = FE010 from edge k, m0_ack pulse at edge k+2, rdata = 8'hEA, m1_ack stays 0.
- Single write: m1 writes 8'h41 to 20'hB8000 -> mem_we high exactly 1 cycle with mem_wdata = 8'h41, m1_ack at k+2, rdata unchanged.
- Contention: m0 and m1 both hold req from reset release for 4 accesses -> grant order m0, m1, m0, m1; owner toggles; 4 cycles per access.
- Back-to-back single master: m0 issues 3 reads, each dropping req the edge after ack -> exactly 3 acks, no duplicate access, 4 cycles apart.
- Reset mid-access: reset_n low during ACCESS -> no ack, all outputs at reset values next edge. After release, a pending m1 request completes normally.
- Req withdrawn: m0 drops req in the first ACCESS cycle -> access completes and m0_ack still pulses. LATENCY = 5 build gives ack at k+5.
